// File: rtl/dac_tx.sv
// ---------------------------------------------------------------------------
// dac_tx
//
// Serial transmitter for the 12-bit DAC channel. A 12-bit sample is accepted
// on a tx_start strobe while the block is idle. It is framed as a 16-bit word
// {2'b00, PD_MODE, din} and shifted out MSB-first while sync is held low.
// The block runs on the same slow serial clock that is routed to the DAC
// SCLK pin. Each bit changes on a rising edge and is stable across the
// following falling edge, which is where the DAC latches it.
//
// Frame timing, with the sample accepted on rising edge k:
//   k .. k+15 : SHIFT, sync low, sdata = frame bit 15 .. 0
//   k+16      : GAP,   sync high, tx_done_tick high, sdata low
//   k+17      : IDLE,  tx_ready high; the earliest next acceptance is k+18
//
// Parameters:
//   PD_MODE      power-down field placed in frame bits [13:12] (00 = normal)
//
// Ports:
//   sclk         serial/system clock
//   rst          asynchronous, active-high reset
//   tx_start     request to send din; honoured only while tx_ready is high
//   din[11:0]    sample to transmit; captured on the accepting edge
//   tx_ready     high while idle and able to accept a new sample
//   tx_done_tick one-cycle pulse after the 16th bit has been driven
//   sync         DAC frame select, active-low, low for exactly 16 cycles
//   sdata        serial data, MSB first
// ---------------------------------------------------------------------------
module dac_tx #(
    parameter logic [1:0] PD_MODE = 2'b00
) (
    input  logic        sclk,
    input  logic        rst,
    input  logic        tx_start,
    input  logic [11:0] din,
    output logic        tx_ready,
    output logic        tx_done_tick,
    output logic        sync,
    output logic        sdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [15:0] shreg_q;
    logic [15:0] shreg_d;
    logic [3:0]  cnt_q;
    logic [3:0]  cnt_d;
    logic [15:0] frame_word;

    // The two don't-care bits are driven as zero. The sample is captured
    // only through the shift-register load, so din may change freely after
    // the sample has been accepted.
    assign frame_word = {2'b00, PD_MODE, din};

    // State, shift register and bit counter. The reset is asynchronous, so
    // an abort in mid-frame raises sync and drops sdata at once, without
    // waiting for a clock edge.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= 16'h0000;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and output decode. Every output comes from the state
    // register or the shift register, never from tx_start. As a result sync
    // cannot glitch low outside SHIFT.
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        cnt_d        = cnt_q;
        sync         = 1'b1;
        tx_ready     = 1'b0;
        tx_done_tick = 1'b0;

        unique case (state_q)
            IDLE: begin
                tx_ready = 1'b1;
                shreg_d  = 16'h0000;
                if (tx_start) begin
                    shreg_d = frame_word;
                    cnt_d   = 4'd0;
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                sync    = 1'b0;
                shreg_d = {shreg_q[14:0], 1'b0};
                cnt_d   = cnt_q + 4'd1;
                // The final shift empties the register, so sdata is already
                // low when the block enters GAP. The counter wraps to 0 here.
                if (cnt_q == 4'd15) begin
                    state_d = GAP;
                end
            end

            GAP: begin
                tx_done_tick = 1'b1;
                shreg_d      = 16'h0000;
                state_d      = IDLE;
            end

            default: begin
                shreg_d = 16'h0000;
                cnt_d   = 4'd0;
                state_d = IDLE;
            end
        endcase
    end

    assign sdata = shreg_q[15];

endmodule

// File: tb/tb_dac_tx.sv
// ---------------------------------------------------------------------------
// tb_dac_tx
//
// Directed, self-checking bench for dac_tx. The bench uses two instances:
// dut with PD_MODE = 00, and dut_pd with PD_MODE = 11. Both share the clock
// and the reset. Serial data is sampled on the falling edge of sclk, which
// is where the DAC samples it. Control outputs are sampled 1 time unit after
// the rising edge.
// ---------------------------------------------------------------------------
module tb_dac_tx;

    logic        sclk;
    logic        clk_en;
    logic        rst;
    logic        tx_start;
    logic [11:0] din;
    logic        tx_ready;
    logic        tx_done_tick;
    logic        sync;
    logic        sdata;

    logic        tx_start_pd;
    logic [11:0] din_pd;
    logic        tx_ready_pd;
    logic        tx_done_tick_pd;
    logic        sync_pd;
    logic        sdata_pd;

    int errors;
    int checks;
    int cyc;

    dac_tx #(.PD_MODE(2'b00)) dut (
        .sclk         (sclk),
        .rst          (rst),
        .tx_start     (tx_start),
        .din          (din),
        .tx_ready     (tx_ready),
        .tx_done_tick (tx_done_tick),
        .sync         (sync),
        .sdata        (sdata)
    );

    dac_tx #(.PD_MODE(2'b11)) dut_pd (
        .sclk         (sclk),
        .rst          (rst),
        .tx_start     (tx_start_pd),
        .din          (din_pd),
        .tx_ready     (tx_ready_pd),
        .tx_done_tick (tx_done_tick_pd),
        .sync         (sync_pd),
        .sdata        (sdata_pd)
    );

    // Gated clock, so that reset values can be observed with sclk stopped.
    initial sclk = 1'b0;
    always begin
        #5;
        if (clk_en) sclk = ~sclk;
    end

    always @(posedge sclk) cyc <= cyc + 1;

    // Waits up to a bounded number of rising edges for sync to go low, that
    // is, for a start request to be accepted. The task returns with the
    // simulation 1 time unit after the accepting edge.
    task automatic wait_accept(input bit sel, output bit seen, output int at_cyc);
        seen   = 1'b0;
        at_cyc = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge sclk);
            #1;
            if ((sel ? sync_pd : sync) == 1'b0) begin
                seen   = 1'b1;
                at_cyc = cyc;
                break;
            end
        end
    endtask

    // Collects the 16 serial bits at successive falling edges. It also
    // counts how many of those edges see sync low and tx_done_tick high.
    task automatic shift_in(input bit sel, output logic [15:0] word,
                            output int low_cnt, output int done_cnt);
        word     = 16'h0000;
        low_cnt  = 0;
        done_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge sclk);
            word[15-i] = sel ? sdata_pd : sdata;
            if ((sel ? sync_pd : sync) == 1'b0) low_cnt++;
            if ((sel ? tx_done_tick_pd : tx_done_tick) == 1'b1) done_cnt++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #2;
        checks++;
        if (sync !== 1'b1) begin errors++; $display("[TB] FAIL reset_sync: got %b expected 1", sync); end
        checks++;
        if (sdata !== 1'b0) begin errors++; $display("[TB] FAIL reset_sdata: got %b expected 0", sdata); end
        checks++;
        if (tx_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx_ready: got %b expected 1", tx_ready); end
        checks++;
        if (tx_done_tick !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", tx_done_tick); end
        clk_en = 1'b1;
        repeat (3) @(posedge sclk);
        @(negedge sclk);
        rst = 1'b0;
        repeat (2) @(negedge sclk);
    endtask

    task automatic test_single_frame;
        bit          seen;
        int          k;
        logic [15:0] word;
        int          low_cnt;
        int          done_cnt;
        @(negedge sclk);
        din      = 12'hA5C;
        tx_start = 1'b1;
        wait_accept(1'b0, seen, k);
        tx_start = 1'b0;
        din      = 12'h000;
        checks++;
        if (!seen) begin errors++; $display("[TB] FAIL single_accept: got timeout expected acceptance"); end
        shift_in(1'b0, word, low_cnt, done_cnt);
        checks++;
        if (word !== 16'h0A5C) begin errors++; $display("[TB] FAIL single_word: got %h expected 0a5c", word); end
        checks++;
        if (low_cnt != 16) begin errors++; $display("[TB] FAIL single_sync_low: got %0d expected 16", low_cnt); end
        checks++;
        if (done_cnt != 0) begin errors++; $display("[TB] FAIL single_early_done: got %0d expected 0", done_cnt); end
        @(posedge sclk);
        #1;
        checks++;
        if ({sync, tx_done_tick, sdata, tx_ready} !== 4'b1100) begin
            errors++;
            $display("[TB] FAIL single_k16: got sync/done/sdata/ready=%b expected 1100",
                     {sync, tx_done_tick, sdata, tx_ready});
        end
        @(posedge sclk);
        #1;
        checks++;
        if ({sync, tx_done_tick, tx_ready} !== 3'b101) begin
            errors++;
            $display("[TB] FAIL single_k17: got sync/done/ready=%b expected 101",
                     {sync, tx_done_tick, tx_ready});
        end
    endtask

    task automatic test_back_to_back;
        bit          seen;
        int          k0;
        int          k1;
        int          high_cnt;
        logic [15:0] word;
        int          low_cnt;
        int          done_cnt;
        @(negedge sclk);
        din      = 12'hFFF;
        tx_start = 1'b1;
        wait_accept(1'b0, seen, k0);
        din = 12'h001;
        checks++;
        if (!seen) begin errors++; $display("[TB] FAIL b2b_accept0: got timeout expected acceptance"); end
        shift_in(1'b0, word, low_cnt, done_cnt);
        checks++;
        if (word !== 16'h0FFF) begin errors++; $display("[TB] FAIL b2b_word0: got %h expected 0fff", word); end
        // sync must be high at k+16 and at k+17, and low again from k+18.
        high_cnt = 0;
        for (int n = 0; n < 2; n++) begin
            @(posedge sclk);
            #1;
            if (sync === 1'b1) high_cnt++;
        end
        checks++;
        if (high_cnt != 2) begin errors++; $display("[TB] FAIL b2b_gap_high: got %0d expected 2", high_cnt); end
        wait_accept(1'b0, seen, k1);
        tx_start = 1'b0;
        checks++;
        if (!seen || (k1 - k0) != 18) begin
            errors++;
            $display("[TB] FAIL b2b_period: got %0d expected 18", k1 - k0);
        end
        shift_in(1'b0, word, low_cnt, done_cnt);
        checks++;
        if (word !== 16'h0001) begin errors++; $display("[TB] FAIL b2b_word1: got %h expected 0001", word); end
        checks++;
        if (low_cnt != 16) begin errors++; $display("[TB] FAIL b2b_sync_low: got %0d expected 16", low_cnt); end
        repeat (2) @(posedge sclk);
        #1;
    endtask

    task automatic test_ignored_start;
        bit          seen;
        int          k;
        logic [15:0] word;
        int          ready_high;
        int          extra_low;
        @(negedge sclk);
        din      = 12'h800;
        tx_start = 1'b1;
        wait_accept(1'b0, seen, k);
        tx_start = 1'b0;
        checks++;
        if (!seen) begin errors++; $display("[TB] FAIL ignore_accept: got timeout expected acceptance"); end
        word       = 16'h0000;
        ready_high = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge sclk);
            word[15-i] = sdata;
            if (tx_ready !== 1'b0) ready_high++;
            if (i == 5) begin
                din      = 12'h123;
                tx_start = 1'b1;
            end
            if (i == 6) tx_start = 1'b0;
        end
        checks++;
        if (word !== 16'h0800) begin errors++; $display("[TB] FAIL ignore_word: got %h expected 0800", word); end
        @(posedge sclk);
        #1;
        if (tx_ready !== 1'b0) ready_high++;
        checks++;
        if (ready_high != 0) begin errors++; $display("[TB] FAIL ignore_ready: got %0d high samples expected 0", ready_high); end
        @(posedge sclk);
        #1;
        checks++;
        if (tx_ready !== 1'b1) begin errors++; $display("[TB] FAIL ignore_ready_k17: got %b expected 1", tx_ready); end
        extra_low = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge sclk);
            if (sync !== 1'b1) extra_low++;
        end
        checks++;
        if (extra_low != 0) begin errors++; $display("[TB] FAIL ignore_no_extra: got %0d low samples expected 0", extra_low); end
    endtask

    task automatic test_power_down;
        bit          seen;
        int          k;
        logic [15:0] word;
        int          low_cnt;
        int          done_cnt;
        @(negedge sclk);
        din_pd      = 12'h000;
        tx_start_pd = 1'b1;
        wait_accept(1'b1, seen, k);
        tx_start_pd = 1'b0;
        checks++;
        if (!seen) begin errors++; $display("[TB] FAIL pd_accept: got timeout expected acceptance"); end
        shift_in(1'b1, word, low_cnt, done_cnt);
        checks++;
        if (word !== 16'h3000) begin errors++; $display("[TB] FAIL pd_word: got %h expected 3000", word); end
        @(posedge sclk);
        #1;
        checks++;
        if (tx_done_tick_pd !== 1'b1) begin errors++; $display("[TB] FAIL pd_done: got %b expected 1", tx_done_tick_pd); end
        repeat (2) @(posedge sclk);
    endtask

    task automatic test_reset_mid_frame;
        bit          seen;
        int          k;
        int          done_seen;
        logic [15:0] word;
        int          low_cnt;
        int          done_cnt;
        @(negedge sclk);
        din      = 12'hFFF;
        tx_start = 1'b1;
        wait_accept(1'b0, seen, k);
        tx_start = 1'b0;
        // The ninth falling edge falls in cycle k+8, where frame bit 7
        // (a 1 in 0FFF) is on sdata.
        repeat (9) @(negedge sclk);
        checks++;
        if ({sync, sdata} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL midrst_before: got sync/sdata=%b expected 01", {sync, sdata});
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({sync, sdata, tx_done_tick, tx_ready} !== 4'b1001) begin
            errors++;
            $display("[TB] FAIL midrst_async: got sync/sdata/done/ready=%b expected 1001",
                     {sync, sdata, tx_done_tick, tx_ready});
        end
        done_seen = 0;
        for (int n = 0; n < 3; n++) begin
            @(posedge sclk);
            #1;
            if (tx_done_tick !== 1'b0) done_seen++;
        end
        @(negedge sclk);
        rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(posedge sclk);
            #1;
            if (tx_done_tick !== 1'b0) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin errors++; $display("[TB] FAIL midrst_no_done: got %0d expected 0", done_seen); end
        @(negedge sclk);
        din      = 12'h5A5;
        tx_start = 1'b1;
        wait_accept(1'b0, seen, k);
        tx_start = 1'b0;
        checks++;
        if (!seen) begin errors++; $display("[TB] FAIL midrst_accept: got timeout expected acceptance"); end
        shift_in(1'b0, word, low_cnt, done_cnt);
        checks++;
        if (word !== 16'h05A5) begin errors++; $display("[TB] FAIL midrst_word: got %h expected 05a5", word); end
        checks++;
        if (low_cnt != 16) begin errors++; $display("[TB] FAIL midrst_sync_low: got %0d expected 16", low_cnt); end
        @(posedge sclk);
        #1;
        checks++;
        if (tx_done_tick !== 1'b1) begin errors++; $display("[TB] FAIL midrst_done: got %b expected 1", tx_done_tick); end
        repeat (2) @(posedge sclk);
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        cyc         = 0;
        clk_en      = 1'b0;
        rst         = 1'b0;
        tx_start    = 1'b0;
        din         = 12'h000;
        tx_start_pd = 1'b0;
        din_pd      = 12'h000;

        test_reset();
        test_single_frame();
        test_back_to_back();
        test_ignored_start();
        test_power_down();
        test_reset_mid_frame();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dac_tx.md
# dac_tx

Serial transmitter for the 12-bit DAC channel, the output-side counterpart of the ADC serial receiver in the servo datapath. The block accepts a 12-bit sample on a start strobe, frames it as a 16-bit word (2 don't-care bits, 2 power-down bits, 12 data bits) and shifts it out MSB-first under an active-low SYNC. It runs on the same slow serial clock that is routed to the converter pins, so the DAC samples `sdata` on the falling edge.

## Interface
- `PD_MODE`, default 2'b00: power-down field placed in frame bits [13:12]; 00 selects normal operation.
- `sclk`  in  1  serial/system clock; also drives the DAC SCLK pin externally.
- `rst`  in  1  reset; asynchronous, active-high.
- `tx_start`  in  1  request to send `din`; sampled on posedge `sclk`; honoured only in IDLE.
- `din`  in  12  sample to transmit; captured on the accepting edge, free to change afterwards.
- `tx_ready`  out  1  high in IDLE; a `tx_start` is accepted only when this is high.
- `tx_done_tick`  out  1  one-cycle pulse after the 16th bit has been driven.
- `sync`  out  1  DAC frame select, active-low; low exactly for the 16 data cycles.
- `sdata`  out  1  serial data, MSB first.

## Operation
- State machine: IDLE, SHIFT, GAP. All outputs come from registers or from state decode; `sdata` is bit 15 of the shift register.
- Frame word: {2'b00, PD_MODE, din}, 16 bits.
- **IDLE**:
  - `sync`=1, `tx_ready`=1, shift register = 0, so `sdata`=0.
  - On `tx_start`=1: load the frame word, clear the bit counter and go to SHIFT.
- **SHIFT**:
  - `sync`=0, `tx_ready`=0.
  - Each posedge shifts the register left by one (zero fill) and increments the 4-bit counter.
  - When the counter is 15 on a posedge, do the final shift. The counter wraps to 0 and the state goes to GAP.
- **GAP**:
  - `sync`=1, `tx_done_tick`=1, `tx_ready`=0.
  - The shift register already holds 0, so `sdata`=0.
  - Next posedge goes unconditionally to IDLE.
- `tx_start` in SHIFT or GAP is ignored; it is not queued.
- If `tx_start` is held high, the block sends back-to-back frames with an 18-cycle period.
- `din` changes after acceptance have no effect on the frame in flight.

## Timing
- Reset values (asynchronous, immediate):
  - state=IDLE, counter=0, shift register=0.
  - `sync`=1, `sdata`=0, `tx_ready`=1, `tx_done_tick`=0.
- Reset mid-frame: `sync` rises and `sdata` drops asynchronously. The frame is aborted with no `tx_done_tick`, and the block restarts in IDLE after `rst` deasserts.
- Acceptance at posedge k, then:
  - From posedge k: `sync`=0 and `sdata` = frame bit 15.
  - Frame bit 15-i is held on `sdata` from posedge k+i to posedge k+i+1, for i=0..15. It is stable at the intervening negedge, where the DAC latches it.
- Posedge k+16: `sync`=1, `tx_done_tick`=1, `sdata`=0.
- Posedge k+17: IDLE, `tx_ready`=1, `tx_done_tick`=0.
- Earliest next acceptance is posedge k+18. `sync` stays high for at least 2 cycles between frames.
- `sync` is low for exactly 16 `sclk` cycles per frame. It never glitches low outside SHIFT.

## Test plan
- **Reset values**: assert `rst` with no clock running. Required: `sync`=1, `sdata`=0, `tx_ready`=1, `tx_done_tick`=0.
- **Single frame**: `din`=12'hA5C, `PD_MODE`=00, one-cycle `tx_start`. Required:
  - `sync` low for exactly 16 cycles.
  - `sdata` sampled at each negedge reads 0000_1010_0101_1100.
  - `tx_done_tick` high for 1 cycle at k+16.
  - `tx_ready` high again at k+17.
- **Back-to-back**: `tx_start` held high with `din`=12'hFFF, then 12'h001. Required:
  - Frames 0000_1111_1111_1111 and 0000_0000_0000_0001.
  - Acceptances 18 cycles apart; `sync` high for 2 cycles between frames.
- **Ignored start and din change**: pulse `tx_start` with `din`=12'h123 at cycle 5 of a frame carrying 12'h800. Required:
  - Frame in flight is unchanged (0000_1000_0000_0000).
  - No extra frame is sent; `tx_ready` stays 0 until k+17.
- **Power-down field**: instantiate with `PD_MODE`=2'b11 and send `din`=12'h000. Required: serial word 0011_0000_0000_0000.
- **Reset mid-frame**: assert `rst` at bit 7 of a frame. Required:
  - `sync`=1 and `sdata`=0 immediately, with no `tx_done_tick`.
  - After release, a new `tx_start` with 12'h5A5 produces a clean full frame.
